bcd_seg_mux: RTL

- Two-digit, time-multiplexed seven-segment display driver for the 8-bit BCD sum word: tens in [7:4], ones in [3:0].
- Sits directly downstream of the single-digit BCD adder and consumes its S output.
- Latches the sum on a load strobe and scans both digits on a shared active-low segment bus, with a one-cycle blanking gap between digits to prevent ghosting.
- Flags non-BCD nibbles.

---
 rtl/bcd_seg_mux.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_seg_mux.sv
// bcd_seg_mux: two-digit, time-multiplexed seven-segment driver for an 8-bit
// BCD word (tens in [7:4], ones in [3:0]). The word is latched on load and
// scanned ones -> blank -> tens -> blank on a shared active-low segment bus.
// Every output is registered, so each output shows the state and held word
// from the previous cycle.
// Optional build macro: LEADING_ZERO_BLANK_EN. When it is defined, a tens
// digit of 0 is kept dark and the scan timing does not change.
module bcd_seg_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] bcd_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err,
  output logic       frame
);

  typedef enum logic [1:0] {
    SHOW_ONES = 2'd0,
    GAP_T     = 2'd1,
    SHOW_TENS = 2'd2,
    GAP_O     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [6:0]       SEG_OFF  = 7'b1111111;

  // Segment pattern (active-low, a..g) for one nibble; 10-15 show a dash.
  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111110;
    endcase
    return s;
  endfunction

  // High when either nibble of the word is not a valid BCD digit.
  function automatic logic bcd_invalid(input logic [7:0] w);
    return (w[7:4] > 4'd9) | (w[3:0] > 4'd9);
  endfunction

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [7:0]       disp_r;
  logic             err_r;
  logic [6:0]       seg_r, seg_nxt_s;
  logic [1:0]       an_r, an_nxt_s;
  logic             frame_r, frame_nxt_s;

  // Scan state and refresh counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= SHOW_ONES;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next scan state: digit windows run to terminal count, gaps last one cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      SHOW_ONES: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = GAP_T;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      GAP_T: begin
        cnt_nxt_s   = CNT_ZERO;
        state_nxt_s = SHOW_TENS;
      end
      SHOW_TENS: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = GAP_O;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      GAP_O: begin
        cnt_nxt_s   = CNT_ZERO;
        state_nxt_s = SHOW_ONES;
      end
      default: begin
        cnt_nxt_s   = CNT_ZERO;
        state_nxt_s = SHOW_ONES;
      end
    endcase
  end

  // Next output values from the current scan state and the held word.
  always_comb begin
    seg_nxt_s   = SEG_OFF;
    an_nxt_s    = 2'b11;
    frame_nxt_s = 1'b0;
    case (state_r)
      SHOW_ONES: begin
        seg_nxt_s = decode7(disp_r[3:0]);
        an_nxt_s  = 2'b10;
      end
      SHOW_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (disp_r[7:4] == 4'd0) begin
          seg_nxt_s = SEG_OFF;
          an_nxt_s  = 2'b11;
        end else begin
          seg_nxt_s = decode7(disp_r[7:4]);
          an_nxt_s  = 2'b01;
        end
`else
        seg_nxt_s = decode7(disp_r[7:4]);
        an_nxt_s  = 2'b01;
`endif
      end
      GAP_T: begin
        seg_nxt_s = SEG_OFF;
        an_nxt_s  = 2'b11;
      end
      GAP_O: begin
        seg_nxt_s   = SEG_OFF;
        an_nxt_s    = 2'b11;
        frame_nxt_s = 1'b1;
      end
      default: begin
        seg_nxt_s   = SEG_OFF;
        an_nxt_s    = 2'b11;
        frame_nxt_s = 1'b0;
      end
    endcase
  end

  // Held display word and its validity flag; a load never disturbs the scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_r <= 8'h00;
      err_r  <= 1'b0;
    end else if (load) begin
      disp_r <= bcd_in;
      err_r  <= bcd_invalid(bcd_in);
    end else begin
      disp_r <= disp_r;
      err_r  <= err_r;
    end
  end

  // Registered segment, anode and frame outputs; blank during reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_r   <= SEG_OFF;
      an_r    <= 2'b11;
      frame_r <= 1'b0;
    end else begin
      seg_r   <= seg_nxt_s;
      an_r    <= an_nxt_s;
      frame_r <= frame_nxt_s;
    end
  end

  assign seg   = seg_r;
  assign an    = an_r;
  assign err   = err_r;
  assign frame = frame_r;

endmodule
